// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane helpers for the SRAM responder.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] addr);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr[0];
      HSIZE_WORD: ok = (addr == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Byte-writable synchronous SRAM, one write port and one registered read port.
// Kept as its own module so a memory macro can be dropped in.
module ahb_sram_bank #(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata,
  input  logic [3:0]           we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  // Byte-lane writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read-first registered read; holds its value until the next read
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder with programmable wait states.
// Define AHB_SRAM_ERR_EN to build the two-cycle ERROR response for illegal transfers.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HMASTLOCK,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

  state_t               state, state_n;
  logic [2:0]           wcnt, wcnt_n;
  logic                 ready_n, resp_n;
  logic [ADDR_BITS+1:0] addr_q;
  logic [2:0]           size_q;
  logic                 write_q, bad_q;
  logic [3:0]           fwd_mask;
  logic [31:0]          fwd_data, ram_q, merge_mask;
  logic                 accept, take, legal, data_done, commit, rd_take, hazard;
  logic [3:0]           we;
  logic [ADDR_BITS-1:0] word_a, word_q;
  logic                 unused_ok;

  assign unused_ok  = ^{HMASTLOCK, HBURST, HPROT, HTRANS[0], HADDR[31:ADDR_BITS+2]};

  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign take       = accept & HREADYOUT;
  assign legal      = xfer_legal(HSIZE, HADDR[1:0]);
  assign word_a     = HADDR[ADDR_BITS+1:2];
  assign word_q     = addr_q[ADDR_BITS+1:2];
  assign data_done  = (state == ST_DATA) && (wcnt == 3'd0);
  assign commit     = data_done & write_q & ~bad_q & ~HRESET;
  assign we         = commit ? byte_en(size_q, addr_q[1:0]) : 4'b0000;
  assign rd_take    = take & ~HWRITE;
  // A read accepted on the edge that commits a write to the same word sees stale RAM data
  assign hazard     = rd_take & commit & (word_a == word_q);
  assign merge_mask = lane_mask(fwd_mask);

  ahb_sram_bank #(
    .ADDR_BITS(ADDR_BITS)
  ) u_bank (
    .clk  (HCLK),
    .re   (rd_take),
    .raddr(word_a),
    .rdata(ram_q),
    .we   (we),
    .waddr(word_q),
    .wdata(HWDATA)
  );

  // Next state and wait counter
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    if ((state == ST_DATA) && (wcnt != 3'd0)) begin
      wcnt_n = wcnt - 3'd1;
`ifdef AHB_SRAM_ERR_EN
    end else if (state == ST_ERR1) begin
      state_n = ST_ERR2;
      wcnt_n  = 3'd0;
    end else if (accept) begin
      state_n = legal ? ST_DATA : ST_ERR1;
      wcnt_n  = legal ? WS_LOAD : 3'd0;
`else
    end else if (accept) begin
      state_n = ST_DATA;
      wcnt_n  = WS_LOAD;
`endif
    end else begin
      state_n = ST_IDLE;
      wcnt_n  = 3'd0;
    end
  end

  // Response values for the next cycle, registered below
  always_comb begin
    ready_n = 1'b1;
    resp_n  = HRESP_OKAY;
    case (state_n)
      ST_DATA: ready_n = (wcnt_n == 3'd0);
      ST_ERR1: begin
        ready_n = 1'b0;
        resp_n  = HRESP_ERROR;
      end
      ST_ERR2: resp_n = HRESP_ERROR;
      default: ready_n = 1'b1;
    endcase
  end

  // Read data is only driven in the final cycle of a legal read data phase
  always_comb begin
    if (data_done && !write_q && !bad_q) begin
      HRDATA = (ram_q & ~merge_mask) | (fwd_data & merge_mask);
    end else begin
      HRDATA = 32'h0000_0000;
    end
  end

  // FSM, response and data-phase registers
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      wcnt      <= 3'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      addr_q    <= '0;
      size_q    <= 3'd0;
      write_q   <= 1'b0;
      bad_q     <= 1'b0;
      fwd_mask  <= 4'b0000;
      fwd_data  <= 32'h0000_0000;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      HREADYOUT <= ready_n;
      HRESP     <= resp_n;
      if (take) begin
        addr_q  <= HADDR[ADDR_BITS+1:0];
        size_q  <= HSIZE;
        write_q <= HWRITE;
        bad_q   <= ~legal;
      end
      if (rd_take) begin
        fwd_mask <= hazard ? we : 4'b0000;
        fwd_data <= HWDATA;
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two responders (0 and 3 wait states), directed tables plus random traffic
// checked against a word-array memory model. Honours AHB_SRAM_ERR_EN for expected responses.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

`ifdef AHB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  // kind: 0 NONSEQ, 4 SEQ, 1 IDLE, 2 BUSY, 3 NONSEQ with HSEL low
  typedef struct {
    int          kind;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          has_exp;
    logic [31:0] exp_data;
    bit          exp_resp;
    int          exp_low;
  } xfer_t;

  logic        clk = 1'b0;
  logic        hreset_v   [2];
  logic        hsel_v     [2];
  logic [1:0]  htrans_v   [2];
  logic        hwrite_v   [2];
  logic [2:0]  hsize_v    [2];
  logic [31:0] haddr_v    [2];
  logic [31:0] hwdata_v   [2];
  logic        hreadyout_v[2];
  logic [31:0] hrdata_v   [2];
  logic        hresp_v    [2];

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [int];

  always #5 clk = ~clk;

  ahb_sram_slave #(.ADDR_BITS(12), .WAIT_STATES(WS0)) dut0 (
    .HCLK(clk), .HRESET(hreset_v[0]), .HSEL(hsel_v[0]), .HTRANS(htrans_v[0]),
    .HWRITE(hwrite_v[0]), .HMASTLOCK(1'b0), .HSIZE(hsize_v[0]), .HBURST(3'b001),
    .HPROT(4'b0011), .HADDR(haddr_v[0]), .HWDATA(hwdata_v[0]), .HREADY(hreadyout_v[0]),
    .HREADYOUT(hreadyout_v[0]), .HRDATA(hrdata_v[0]), .HRESP(hresp_v[0])
  );

  ahb_sram_slave #(.ADDR_BITS(12), .WAIT_STATES(WS1)) dut1 (
    .HCLK(clk), .HRESET(hreset_v[1]), .HSEL(hsel_v[1]), .HTRANS(htrans_v[1]),
    .HWRITE(hwrite_v[1]), .HMASTLOCK(1'b0), .HSIZE(hsize_v[1]), .HBURST(3'b001),
    .HPROT(4'b0011), .HADDR(haddr_v[1]), .HWDATA(hwdata_v[1]), .HREADY(hreadyout_v[1]),
    .HREADYOUT(hreadyout_v[1]), .HRDATA(hrdata_v[1]), .HRESP(hresp_v[1])
  );

  function automatic xfer_t mk(input int kind, input bit write, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata, input bit has_exp,
                               input logic [31:0] exp_data, input bit exp_resp, input int exp_low);
    xfer_t x;
    x.kind = kind; x.write = write; x.size = size; x.addr = addr; x.wdata = wdata;
    x.has_exp = has_exp; x.exp_data = exp_data; x.exp_resp = exp_resp; x.exp_low = exp_low;
    return x;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  function automatic bit legal_of(input logic [2:0] size, input logic [31:0] addr);
    int n;
    if (size > 3'd2) return 1'b0;
    n = 1 << size;
    return (int'(addr[1:0]) % n) == 0;
  endfunction

  function automatic int key_of(input int d, input logic [31:0] addr);
    return d * 4096 + int'((addr >> 2) & 32'h0000_0FFF);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic mdl_write(input int d, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] data);
    int k;
    int lo;
    int n;
    logic [31:0] w;
    k  = key_of(d, addr);
    w  = mdl.exists(k) ? mdl[k] : 32'h0;
    lo = int'(addr[1:0]);
    n  = 1 << size;
    for (int b = 0; b < 4; b++) begin
      if (b >= lo && b < lo + n) w[8*b +: 8] = data[8*b +: 8];
    end
    mdl[k] = w;
  endtask

  task automatic drive_addr(input int d, input xfer_t x);
    hsel_v[d] = (x.kind != 3);
    case (x.kind)
      1:       htrans_v[d] = HTRANS_IDLE;
      2:       htrans_v[d] = HTRANS_BUSY;
      4:       htrans_v[d] = HTRANS_SEQ;
      default: htrans_v[d] = HTRANS_NONSEQ;
    endcase
    hwrite_v[d] = x.write;
    hsize_v[d]  = x.size;
    haddr_v[d]  = x.addr;
  endtask

  // Pipelined master: address phase of the queue head overlaps the current data phase
  task automatic run_seq(input int d, input xfer_t q[$]);
    xfer_t dp;
    xfer_t idle_x;
    bit dp_v;
    bit ill;
    bit e_resp;
    int e_low;
    int low;
    int guard;
    logic [31:0] e_data;
    idle_x = mk(1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    dp = idle_x;
    dp_v = 1'b0;
    low = 0;
    guard = 0;
    while ((q.size() > 0 || dp_v) && guard < 4000) begin
      if (q.size() > 0) drive_addr(d, q[0]);
      else drive_addr(d, idle_x);
      hwdata_v[d] = (dp_v && dp.write) ? dp.wdata : 32'h0;
      #1;
      if (dp_v) begin
        ill    = !legal_of(dp.size, dp.addr);
        e_resp = ill && ERR_EN;
        e_low  = e_resp ? 1 : ws_of(d);
        if (!hreadyout_v[d]) begin
          low++;
          check("wait_resp", 32'(hresp_v[d]), 32'(e_resp));
          check("wait_rdata", hrdata_v[d], 32'h0);
          if (low > e_low) check("wait_len", 32'(low), 32'(e_low));
        end else begin
          e_data = (!dp.write && !ill) ? mdl[key_of(d, dp.addr)] : 32'h0;
          check("resp", 32'(hresp_v[d]), 32'(e_resp));
          check("rdata", hrdata_v[d], e_data);
          check("wait_cycles", 32'(low), 32'(e_low));
          if (dp.has_exp) begin
            check("tbl_rdata", hrdata_v[d], dp.exp_data);
            check("tbl_resp", 32'(hresp_v[d]), 32'(dp.exp_resp));
            check("tbl_waits", 32'(low), 32'(dp.exp_low));
          end
          if (dp.write && !ill) mdl_write(d, dp.size, dp.addr, dp.wdata);
          dp_v = 1'b0;
        end
      end else begin
        check("idle_ready", 32'(hreadyout_v[d]), 32'h1);
        check("idle_resp", 32'(hresp_v[d]), 32'h0);
        check("idle_rdata", hrdata_v[d], 32'h0);
      end
      if (hreadyout_v[d] && q.size() > 0) begin
        dp   = q.pop_front();
        dp_v = (dp.kind == 0 || dp.kind == 4);
        low  = 0;
      end
      @(posedge clk);
      @(negedge clk);
      guard++;
    end
    if (guard >= 4000) check("seq_timeout", 32'(guard), 32'h0);
  endtask

  function automatic xfer_t rnd_x();
    xfer_t x;
    int r;
    int rs;
    int off;
    x = mk(0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    r = $urandom_range(0, 99);
    if (r < 6) x.kind = 1;
    else if (r < 10) x.kind = 2;
    else if (r < 14) x.kind = 3;
    else if (r < 30) x.kind = 4;
    else x.kind = 0;
    x.write = 1'($urandom_range(0, 1));
    rs = $urandom_range(0, 19);
    if (rs < 6) x.size = HSIZE_BYTE;
    else if (rs < 12) x.size = HSIZE_HALF;
    else if (rs < 19) x.size = HSIZE_WORD;
    else x.size = 3'($urandom_range(3, 7));
    off = $urandom_range(0, 3);
    if ($urandom_range(0, 9) != 0 && x.size <= 3'd2) off = off & ~((1 << x.size) - 1);
    x.addr = 32'($urandom_range(0, 31) * 4 + off);
    if ($urandom_range(0, 4) == 0) x.addr = x.addr | (32'($urandom_range(1, 15)) << 14);
    x.wdata = $urandom;
    return x;
  endfunction

  initial begin
    xfer_t q[$];
    int el;
    el = ERR_EN ? 1 : 0;
    for (int d = 0; d < 2; d++) begin
      hreset_v[d] = 1'b1; hsel_v[d] = 1'b0; htrans_v[d] = HTRANS_IDLE; hwrite_v[d] = 1'b0;
      hsize_v[d] = 3'd0; haddr_v[d] = 32'h0; hwdata_v[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ready", 32'(hreadyout_v[d]), 32'h1);
      check("rst_resp", 32'(hresp_v[d]), 32'h0);
      check("rst_rdata", hrdata_v[d], 32'h0);
      hreset_v[d] = 1'b0;
    end

    // Give every word of the test window a known value
    for (int d = 0; d < 2; d++) begin
      q = {};
      for (int w = 0; w < 32; w++) q.push_back(mk(0, 1'b1, HSIZE_WORD, 32'(w * 4), $urandom, 1'b0, 32'h0, 1'b0, 0));
      run_seq(d, q);
    end

    // Zero-wait directed table
    q = {};
    q.push_back(mk(0, 1'b1, HSIZE_WORD, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 0));
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0));
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h4010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 0));
    q.push_back(mk(0, 1'b1, HSIZE_WORD, 32'h20, 32'h1122_3344, 1'b0, 32'h0, 1'b0, 0));
    q.push_back(mk(0, 1'b1, HSIZE_BYTE, 32'h21, 32'h0000_AA00, 1'b0, 32'h0, 1'b0, 0));
    q.push_back(mk(0, 1'b1, HSIZE_HALF, 32'h22, 32'hBBBB_0000, 1'b0, 32'h0, 1'b0, 0));
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h20, 32'h0, 1'b1, 32'hBBBB_AA44, 1'b0, 0));
    q.push_back(mk(1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0));
    q.push_back(mk(0, 1'b1, HSIZE_WORD, 32'h00, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 0));
    q.push_back(mk(0, 1'b1, HSIZE_WORD, 32'h02, 32'h5555_5555, 1'b1, 32'h0, ERR_EN, el));
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h00, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 0));
    q.push_back(mk(0, 1'b1, HSIZE_HALF, 32'h01, 32'h7777_7777, 1'b1, 32'h0, ERR_EN, el));
    q.push_back(mk(0, 1'b0, 3'd3, 32'h00, 32'h0, 1'b1, 32'h0, ERR_EN, el));
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h00, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 0));
    q.push_back(mk(0, 1'b1, HSIZE_WORD, 32'h40, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 0));
    q.push_back(mk(0, 1'b1, HSIZE_BYTE, 32'h40, 32'h0000_00FF, 1'b0, 32'h0, 1'b0, 0));
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h40, 32'h0, 1'b1, 32'h1234_56FF, 1'b0, 0));
    q.push_back(mk(4, 1'b0, HSIZE_BYTE, 32'h43, 32'h0, 1'b1, 32'h1234_56FF, 1'b0, 0));
    run_seq(0, q);

    // Three-wait directed table, including a hazard merge held across waits
    q = {};
    q.push_back(mk(0, 1'b1, HSIZE_WORD, 32'h30, 32'h0102_0304, 1'b1, 32'h0, 1'b0, 3));
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h30, 32'h0, 1'b1, 32'h0102_0304, 1'b0, 3));
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h30, 32'h0, 1'b1, 32'h0102_0304, 1'b0, 3));
    q.push_back(mk(0, 1'b1, HSIZE_HALF, 32'h32, 32'hA5A5_0000, 1'b1, 32'h0, 1'b0, 3));
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h30, 32'h0, 1'b1, 32'hA5A5_0304, 1'b0, 3));
    q.push_back(mk(0, 1'b1, HSIZE_WORD, 32'h31, 32'h0, 1'b1, 32'h0, ERR_EN, ERR_EN ? 1 : 3));
    run_seq(1, q);

    // Reset in the middle of a waited write: nothing committed, bus idle afterwards
    drive_addr(1, mk(0, 1'b1, HSIZE_WORD, 32'h30, 32'h0, 1'b0, 32'h0, 1'b0, 0));
    hwdata_v[1] = 32'h0;
    @(posedge clk);
    @(negedge clk);
    drive_addr(1, mk(1, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 0));
    hwdata_v[1] = 32'hFFFF_FFFF;
    #1;
    check("rst_mid_stall", 32'(hreadyout_v[1]), 32'h0);
    @(posedge clk);
    @(negedge clk);
    hreset_v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    hreset_v[1] = 1'b0;
    #1;
    check("rst_mid_ready", 32'(hreadyout_v[1]), 32'h1);
    check("rst_mid_resp", 32'(hresp_v[1]), 32'h0);
    check("rst_mid_rdata", hrdata_v[1], 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    q = {};
    q.push_back(mk(0, 1'b0, HSIZE_WORD, 32'h30, 32'h0, 1'b1, 32'hA5A5_0304, 1'b0, 3));
    run_seq(1, q);

    // Randomised traffic against the model
    for (int d = 0; d < 2; d++) begin
      q = {};
      for (int n = 0; n < 200; n++) q.push_back(rnd_x());
      run_seq(d, q);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder: one slave endpoint of the AHB matrix, connected to a single slave port's S_* signals.
- Serves read/write transfers from an internal byte-writable synchronous SRAM.
- Supports a programmable wait-state count and the two-cycle ERROR response.
- Default configuration is the on-chip data RAM slave behind the matrix.

Parameters:
ADDR_BITS, 12, word-address width; memory = 2^ADDR_BITS x 32 bits (16 KB default)
WAIT_STATES, 0, data-phase wait cycles inserted per transfer (0..7)

Ports:
HCLK  in  1  clock; all logic on rising edge
HRESET  in  1  synchronous reset, active-high
HSEL  in  1  slave select from matrix decoder
HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ)
HWRITE  in  1  1=write
HMASTLOCK  in  1  locked transfer (accepted, no effect)
HSIZE  in  3  transfer size
HBURST  in  3  burst type (accepted, no effect)
HPROT  in  4  protection (accepted, no effect)
HADDR  in  32  byte address
HWDATA  in  32  write data (data phase)
HREADY  in  1  bus-level ready from matrix
HREADYOUT  out  1  this slave's ready
HRDATA  out  32  read data
HRESP  out  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (HRESET=1 at clock edge): HREADYOUT=1, HRESP=0, HRDATA=0, state=ST_IDLE, wait counter=0, pending write dropped. Memory contents are not cleared.
- Reset mid-transfer: the transfer is abandoned and no write is committed.
- Accept condition: HSEL & HTRANS[1] & HREADY. On accept, register addr[ADDR_BITS+1:0], HSIZE and HWRITE into data-phase registers.
- IDLE/BUSY, or HSEL=0: nothing captured; the next data phase is zero-wait OKAY.
- Legality check (at accept):
  - HSIZE>2 is illegal.
  - HSIZE=1 with HADDR[0]=1 is illegal.
  - HSIZE=2 with HADDR[1:0]!=0 is illegal.
- Address bits above ADDR_BITS+1 are ignored (aliasing); range decode belongs to the matrix.
- States:
  - ST_IDLE: no data phase. HREADYOUT=1.
  - ST_DATA: legal transfer in data phase. HREADYOUT=(wcnt==0). wcnt loads WAIT_STATES at accept and decrements each cycle.
  - ST_ERR1: HREADYOUT=0, HRESP=1.
  - ST_ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - Legal accept goes to ST_DATA; illegal accept goes to ST_ERR1.
  - ST_ERR1 always goes to ST_ERR2.
  - From ST_DATA (when HREADYOUT=1) or ST_ERR2: next state follows the accept of the same cycle; otherwise ST_IDLE.
- Read: SRAM read issued combinationally from HADDR in the accept cycle; data registered. With WAIT_STATES=0, HRDATA is valid in the first data-phase cycle.
  - With waits, read data is held stable until HREADYOUT=1.
  - HRDATA=0 in every cycle that is not a read data phase with HREADYOUT=1.
- Write: byte enables derived from size/address.
  - HSIZE=0: lane HADDR[1:0].
  - HSIZE=1: lanes {HADDR[1],0} and {HADDR[1],1}.
  - HSIZE=2: all four lanes.
  - HWDATA is committed to SRAM at the clock edge ending the data phase (HREADYOUT=1). Only enabled lanes change.
- Read-after-write hazard: a read accepted in the same cycle that a write commits to the same word returns the byte-merged value. Written lanes come from HWDATA, others from SRAM. Latency is unchanged.
- Back-to-back transfers: address phase N+1 overlaps data phase N with no bubble at WAIT_STATES=0.
- While HREADYOUT=0 nothing is accepted, because HREADY is low.
- During ERR1/ERR2 no write is committed and HRDATA=0.

Optional Feature:
AHB_SRAM_ERR_EN
- Defined: illegal transfers produce the two-cycle ERROR response described above.
- Undefined: illegal transfers get an OKAY response with WAIT_STATES timing. Writes are dropped, reads return 0, and ST_ERR1/ST_ERR2 are not built.

Decomposition:
- Package ahb_pkg:
  - HTRANS encodings: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - HSIZE encodings: BYTE=0, HALF=1, WORD=2.
  - HRESP OKAY/ERROR constants.
  - State enum: ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2.
  - Byte-enable function (size, addr[1:0] -> 4-bit mask).
- Sub-module ahb_sram_bank: 2^ADDR_BITS x 32 synchronous RAM, 4 byte write enables, 1 read port, read registered. Keeps the RAM separable for macro replacement.

Test Plan:
- Zero-wait word path (WAIT_STATES=0): write 0xDEADBEEF @0x10, then read @0x10 back-to-back. Read data phase shows HRDATA=0xDEADBEEF, HREADYOUT=1, HRESP=0, and there are no stall cycles.
- Byte/halfword lanes: word write 0x11223344 @0x20, then byte write 0xAA on lane 1 (HADDR=0x21, HWDATA=0x0000AA00), then halfword 0xBBBB @0x22, then read @0x20. Read returns 0xBBBBAA44.
- Wait states (WAIT_STATES=3): single read. HREADYOUT low for exactly 3 cycles, then high with valid data. A NONSEQ presented during the waits is accepted only on the HREADY=1 cycle.
- Error (ERR_EN defined): HSIZE=2 @0x02 write. HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. A subsequent read of word 0x00 shows memory unchanged. With ERR_EN undefined: OKAY, write dropped.
- Hazard: write 0x000000FF (byte, lane 0) @0x40 with a read @0x40 in the next address phase. Read returns the merged word in the same latency.
- Reset mid-transfer: assert HRESET during a waited write's data phase. Next cycle HREADYOUT=1, HRESP=0, HRDATA=0, and the target word keeps its prior value.
